// File: rtl/hfrv_trace_buffer_if.sv
// Capture/drain bus for the hf-riscv instruction trace buffer.
//   cap_valid/cap_pc/cap_instr : retired-instruction snapshot from the core
//   out_valid/out_ready        : drain handshake, oldest entry first
//   out_pc/out_instr           : head entry contents
// master = core + drain consumer side, slave = trace buffer.
interface hfrv_trace_buffer_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            cap_valid;
    logic [XLEN-1:0] cap_pc;
    logic [ILEN-1:0] cap_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output cap_valid, cap_pc, cap_instr, out_ready,
        input  out_valid, out_pc, out_instr
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, out_ready,
        output out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/hfrv_trace_buffer.sv
// Instruction-trace capture buffer.
// Records (PC, instr) snapshots into a circular store. Stop mode drops new
// entries when full, wrap mode overwrites the oldest. A PC-match trigger
// freezes capture after POST_TRIG further retired instructions.
// Ports:
//   clk, rst     : clock, async active-high reset
//   clear        : synchronous flush back to an empty RUN buffer
//   bus          : capture input and valid/ready drain (slave modport)
//   mode_wrap    : 0 = stop-when-full, 1 = overwrite oldest
//   trig_en/pc   : trigger arm and match PC
//   count        : entries held (0..DEPTH)
//   overflow     : sticky, an entry was dropped or overwritten
//   frozen       : capture stopped after the post-trigger window
//   triggered    : sticky, trigger matched since last clear/reset
module hfrv_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int ILEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    hfrv_trace_buffer_if.slave  bus,
    input  logic                mode_wrap,
    input  logic                trig_en,
    input  logic [XLEN-1:0]     trig_pc,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic                frozen,
    output logic                triggered
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_RUN, S_POST, S_FROZEN} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [PW-1:0]       post_cnt;
    logic [XLEN+ILEN-1:0] mem [DEPTH];

    logic push_req, pop, full, trig_hit;
    logic wr_en, drop, overwrite;

    assign full = (count == CW'(DEPTH));
    assign pop  = bus.out_valid && bus.out_ready;

    // Full without a pop: stop mode discards the snapshot, wrap mode writes
    // over the head and drags rd_ptr along so count stays at DEPTH.
    assign drop      = push_req && full && !pop && !mode_wrap;
    assign overwrite = push_req && full && !pop &&  mode_wrap;
    assign wr_en     = push_req && !clear && !drop;
    assign trig_hit  = push_req && (state_q == S_RUN) && trig_en && (bus.cap_pc == trig_pc);

    assign bus.out_valid = (count != '0);
    assign {bus.out_pc, bus.out_instr} = mem[rd_ptr];

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (trig_hit) state_d = (POST_TRIG == 0) ? S_FROZEN : S_POST;
                S_POST:  if (bus.cap_valid && post_cnt == PW'(1)) state_d = S_FROZEN;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        frozen   = (state_q == S_FROZEN);
        push_req = bus.cap_valid && (state_q != S_FROZEN);
    end

    // Post-trigger window counts retired instructions, dropped ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  post_cnt <= '0;
        else if (clear)                           post_cnt <= '0;
        else if (trig_hit)                        post_cnt <= PW'(POST_TRIG);
        else if (state_q == S_POST && bus.cap_valid) post_cnt <= post_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
        end else begin
            if (wr_en)             wr_ptr <= wr_ptr + 1'b1;
            if (pop || overwrite)  rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop && !overwrite) count <= count + 1'b1;
            else if (pop && !wr_en)          count <= count - 1'b1;
            if (drop || overwrite) overflow  <= 1'b1;
            if (trig_hit)          triggered <= 1'b1;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bus.cap_pc, bus.cap_instr};
    end
endmodule
